// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encoding, transmitter FSM states, parity helper.
package uart_pkg;

   localparam int unsigned PARITY_NONE   = 0;
   localparam int unsigned PARITY_ODD    = 1;
   localparam int unsigned PARITY_EVEN   = 2;
   localparam int unsigned MAX_DATA_BITS = 9;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } uart_tx_state_t;

   // Zero-extended payload does not change the XOR, so one width serves every frame size.
   function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data,
                                        input int unsigned mode);
      logic even_bit;
      even_bit = ^data;
      return (mode == PARITY_ODD) ? ~even_bit : even_bit;
   endfunction

endpackage

// File: rtl/uart_tx_framer_if.sv
// Write-side valid/ready handshake into the transmitter buffer.
interface uart_tx_framer_if #(
   parameter int unsigned DATA_BITS = 8
) ();

   logic [DATA_BITS-1:0] data_in;
   logic                 data_valid;
   logic                 data_ready;

   modport master (output data_in, output data_valid, input data_ready);
   modport slave  (input data_in, input data_valid, output data_ready);

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-around pointers one bit wider than the address.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk_in,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign count   = wr_ptr - rd_ptr;
   assign rdata   = mem[rd_ptr[AW-1:0]];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Pointer advance; a simultaneous push and pop both take effect.
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // Storage array, not reset.
   always_ff @(posedge clk_in) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/uart_tx_framer.sv
// Buffered UART transmitter: FIFO-fed, LSB-first, optional parity, 1 or 2 stop bits.
module uart_tx_framer
   import uart_pkg::*;
#(
   parameter int unsigned CLK_TICKS_PER_BIT = 9,
   parameter int unsigned CLK_TICKS_WIDTH   = 4,
   parameter int unsigned DATA_BITS         = 8,
   parameter int unsigned PARITY            = 0,
   parameter int unsigned STOP_BITS         = 2,
   parameter int unsigned FIFO_DEPTH        = 4
) (
   input  logic                          clk_in,
   input  logic                          reset,
   uart_tx_framer_if.slave               bus,
   output logic                          tx_out,
   output logic                          tx_busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow
);

   localparam int unsigned BIT_W = $clog2(DATA_BITS);

   uart_tx_state_t             state_q, state_d;
   logic [CLK_TICKS_WIDTH-1:0] tick_q, tick_d;
   logic [BIT_W-1:0]           bit_q, bit_d;
   logic [DATA_BITS-1:0]       shift_q, shift_d;
   logic                       par_q, par_d;
   logic                       tx_d;
   logic                       fifo_pop;
   logic                       fifo_full;
   logic                       fifo_empty;
   logic [DATA_BITS-1:0]       fifo_rdata;
   logic                       tick_last;
   logic                       load;

   assign bus.data_ready = ~fifo_full;

   sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_in (clk_in),
      .reset  (reset),
      .push   (bus.data_valid),
      .wdata  (bus.data_in),
      .pop    (fifo_pop),
      .rdata  (fifo_rdata),
      .full   (fifo_full),
      .empty  (fifo_empty),
      .count  (fifo_count)
   );

   assign tick_last = (tick_q == CLK_TICKS_WIDTH'(CLK_TICKS_PER_BIT - 1));

   // Next-state, bit timing and line value for the state being entered.
   always_comb begin
      state_d  = state_q;
      tick_d   = tick_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      par_d    = par_q;
      fifo_pop = 1'b0;
      load     = 1'b0;
      tx_d     = 1'b1;

      case (state_q)
         ST_IDLE: begin
            load = !fifo_empty;
         end
         ST_START: begin
            if (tick_last) begin
               tick_d  = '0;
               bit_d   = '0;
               state_d = ST_DATA;
            end else begin
               tick_d = tick_q + CLK_TICKS_WIDTH'(1);
            end
         end
         ST_DATA: begin
            if (tick_last) begin
               tick_d  = '0;
               shift_d = shift_q >> 1;
               if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                  bit_d   = '0;
                  state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
               end else begin
                  bit_d = bit_q + BIT_W'(1);
               end
            end else begin
               tick_d = tick_q + CLK_TICKS_WIDTH'(1);
            end
         end
         ST_PARITY: begin
            if (tick_last) begin
               tick_d  = '0;
               bit_d   = '0;
               state_d = ST_STOP;
            end else begin
               tick_d = tick_q + CLK_TICKS_WIDTH'(1);
            end
         end
         ST_STOP: begin
            if (tick_last) begin
               tick_d = '0;
               if (bit_q == BIT_W'(STOP_BITS - 1)) begin
                  bit_d   = '0;
                  state_d = ST_IDLE;
                  load    = !fifo_empty;
               end else begin
                  bit_d = bit_q + BIT_W'(1);
               end
            end else begin
               tick_d = tick_q + CLK_TICKS_WIDTH'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Pop the head word and start a frame without an idle gap.
      if (load) begin
         fifo_pop = 1'b1;
         shift_d  = fifo_rdata;
         par_d    = calc_parity(MAX_DATA_BITS'(fifo_rdata), PARITY);
         tick_d   = '0;
         bit_d    = '0;
         state_d  = ST_START;
      end

      case (state_d)
         ST_START:  tx_d = 1'b0;
         ST_DATA:   tx_d = shift_d[0];
         ST_PARITY: tx_d = par_d;
         default:   tx_d = 1'b1;
      endcase
   end

   // FSM, counters, shift register and registered line outputs.
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         tick_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         tx_out  <= 1'b1;
         tx_busy <= 1'b0;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         tx_out  <= tx_d;
         tx_busy <= (state_d != ST_IDLE);
      end
   end

   // Sticky flag for writes offered while the buffer is full.
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) overflow <= 1'b0;
      else if (bus.data_valid && !bus.data_ready) overflow <= 1'b1;
   end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Bench: four framer configurations driven in parallel against a frame-level model.
module tb_uart_tx_framer;

   localparam int NCFG  = 4;
   localparam int DEPTH = 4;

   function automatic int unsigned cfg_db(input int i);
      return (i == 3) ? 5 : 8;
   endfunction
   function automatic int unsigned cfg_par(input int i);
      return (i == 1) ? 2 : (i == 2) ? 1 : 0;
   endfunction
   function automatic int unsigned cfg_stop(input int i);
      return (i == 1 || i == 2) ? 1 : 2;
   endfunction
   function automatic int unsigned cfg_ticks(input int i);
      return (i == 3) ? 2 : 9;
   endfunction
   function automatic int unsigned cfg_tw(input int i);
      return (i == 3) ? 2 : 4;
   endfunction

   logic             tb_clk_baudrate;
   logic             rst;
   logic             stim_valid;
   logic [8:0]       stim_data;
   logic [NCFG-1:0]  tx_w;
   logic [NCFG-1:0]  busy_w;
   logic [NCFG-1:0]  rdy_w;
   logic [NCFG-1:0]  ovf_w;
   logic [2:0]       cnt_w [NCFG];

   int tests = 0;
   int fails = 0;

   initial begin
      tb_clk_baudrate = 1'b0;
      forever #5 tb_clk_baudrate = ~tb_clk_baudrate;
   end

   for (genvar g = 0; g < NCFG; g++) begin : g_dut
      localparam int unsigned DB = cfg_db(g);
      uart_tx_framer_if #(.DATA_BITS(DB)) bus ();
      assign bus.data_in    = stim_data[DB-1:0];
      assign bus.data_valid = stim_valid;
      assign rdy_w[g]       = bus.data_ready;
      uart_tx_framer #(
         .CLK_TICKS_PER_BIT (cfg_ticks(g)),
         .CLK_TICKS_WIDTH   (cfg_tw(g)),
         .DATA_BITS         (DB),
         .PARITY            (cfg_par(g)),
         .STOP_BITS         (cfg_stop(g)),
         .FIFO_DEPTH        (DEPTH)
      ) u_dut (
         .clk_in     (tb_clk_baudrate),
         .reset      (rst),
         .bus        (bus),
         .tx_out     (tx_w[g]),
         .tx_busy    (busy_w[g]),
         .fifo_count (cnt_w[g]),
         .overflow   (ovf_w[g])
      );
   end

   // Frame-level model: pending-word queue plus the current frame as a bit list.
   int mq   [NCFG][8];
   int mhead[NCFG];
   int mcnt [NCFG];
   int mfb  [NCFG][16];
   int mlen [NCFG];
   int mpos [NCFG];
   bit mact [NCFG];
   bit movf [NCFG];
   int pre_m;
   bit pop_m;

   task automatic build_frame(input int i, input int w);
      int n;
      int ones;
      n = 0;
      ones = 0;
      mfb[i][n++] = 0;
      for (int b = 0; b < int'(cfg_db(i)); b++) begin
         mfb[i][n++] = (w >> b) & 1;
         ones += (w >> b) & 1;
      end
      if (cfg_par(i) == 2) mfb[i][n++] = ones % 2;
      if (cfg_par(i) == 1) mfb[i][n++] = 1 - (ones % 2);
      for (int s = 0; s < int'(cfg_stop(i)); s++) mfb[i][n++] = 1;
      mlen[i] = n;
      mpos[i] = 0;
      mact[i] = 1'b1;
   endtask

   always @(posedge tb_clk_baudrate or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NCFG; i++) begin
            mhead[i] = 0; mcnt[i] = 0; mpos[i] = 0; mlen[i] = 0;
            mact[i] = 1'b0; movf[i] = 1'b0;
         end
      end else begin
         for (int i = 0; i < NCFG; i++) begin
            pre_m = mcnt[i];
            pop_m = 1'b0;
            if (mact[i]) begin
               mpos[i]++;
               if (mpos[i] == mlen[i] * int'(cfg_ticks(i))) begin
                  mact[i] = 1'b0;
                  pop_m = (pre_m > 0);
               end
            end else begin
               pop_m = (pre_m > 0);
            end
            if (pop_m) begin
               build_frame(i, mq[i][mhead[i]]);
               mhead[i] = (mhead[i] + 1) % 8;
               mcnt[i]--;
            end
            if (stim_valid) begin
               if (pre_m < DEPTH) begin
                  mq[i][(mhead[i] + mcnt[i]) % 8] = int'(stim_data) & ((1 << cfg_db(i)) - 1);
                  mcnt[i]++;
               end else begin
                  movf[i] = 1'b1;
               end
            end
         end
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic check_all();
      int exp_tx;
      for (int i = 0; i < NCFG; i++) begin
         exp_tx = mact[i] ? mfb[i][mpos[i] / int'(cfg_ticks(i))] : 1;
         chk($sformatf("tx_out[c%0d]", i), int'(tx_w[i]), exp_tx);
         chk($sformatf("tx_busy[c%0d]", i), int'(busy_w[i]), int'(mact[i]));
         chk($sformatf("fifo_count[c%0d]", i), int'(cnt_w[i]), mcnt[i]);
         chk($sformatf("data_ready[c%0d]", i), int'(rdy_w[i]), int'(mcnt[i] < DEPTH));
         chk($sformatf("overflow[c%0d]", i), int'(ovf_w[i]), int'(movf[i]));
      end
   endtask

   task automatic cyc();
      @(negedge tb_clk_baudrate);
      check_all();
   endtask

   task automatic send(input int w);
      stim_valid = 1'b1;
      stim_data  = 9'(w);
      cyc();
      stim_valid = 1'b0;
   endtask

   task automatic wait_idle(input int budget, output int busy_cycles);
      bit done;
      done = 1'b0;
      busy_cycles = 0;
      for (int c = 0; c < budget && !done; c++) begin
         cyc();
         if (busy_w[0]) busy_cycles++;
         done = (busy_w == '0);
         for (int i = 0; i < NCFG; i++) if (cnt_w[i] != 3'd0) done = 1'b0;
      end
      chk("wait_idle_timeout", int'(done), 1);
   endtask

   initial begin
      logic [10:0] l_frame;
      logic [7:0]  d_frame;
      int          busy_n;
      int          peak;
      int          bad;

      l_frame    = 11'h698;
      d_frame    = 8'hEA;
      stim_valid = 1'b0;
      stim_data  = '0;
      rst        = 1'b0;
      #1 rst     = 1'b1;
      repeat (3) cyc();

      chk("rst_tx_out", int'(tx_w[0]), 1);
      chk("rst_tx_busy", int'(busy_w[0]), 0);
      chk("rst_data_ready", int'(rdy_w[0]), 1);
      chk("rst_fifo_count", int'(cnt_w[0]), 0);
      chk("rst_overflow", int'(ovf_w[0]), 0);
      rst = 1'b0;
      cyc();

      // 'L' = 0x4C: 8N2 line pattern, even/odd parity bits, 99-cycle frame.
      send(9'h04C);
      for (int k = 0; k < 102; k++) begin
         cyc();
         chk("L_tx", int'(tx_w[0]), (k < 99) ? int'(l_frame[k / 9]) : 1);
         chk("L_busy", int'(busy_w[0]), int'(k < 99));
         if (k == 85) begin
            chk("L_even_parity", int'(tx_w[1]), 1);
            chk("L_odd_parity", int'(tx_w[2]), 0);
         end
         if (k == 98) chk("L_par_busy_last", int'(busy_w[1]), 1);
         if (k == 99) chk("L_par_busy_end", int'(busy_w[1]), 0);
      end

      // Back-to-back 'R','r': no idle gap, occupancy never above one.
      stim_valid = 1'b1;
      stim_data  = 9'h052;
      cyc();
      stim_data  = 9'h072;
      cyc();
      stim_valid = 1'b0;
      peak = int'(cnt_w[0]);
      chk("b2b_first_start", int'(tx_w[0]), 0);
      for (int k = 1; k < 200; k++) begin
         cyc();
         if (int'(cnt_w[0]) > peak) peak = int'(cnt_w[0]);
         if (k == 98)  chk("b2b_last_stop", int'(tx_w[0]), 1);
         if (k == 99)  chk("b2b_second_start", int'(tx_w[0]), 0);
         if (k == 197) chk("b2b_busy_end", int'(busy_w[0]), 1);
         if (k == 198) chk("b2b_idle", int'(busy_w[0]), 0);
      end
      chk("b2b_peak_count", peak, 1);

      // Six writes into a depth-4 buffer: five accepted, sixth rejected.
      busy_n = 0;
      stim_valid = 1'b1;
      for (int j = 0; j < 6; j++) begin
         stim_data = 9'(8'hA0 + j);
         cyc();
         if (busy_w[0]) busy_n++;
         if (j == 3) chk("ovf_ready_before", int'(rdy_w[0]), 1);
         if (j == 4) begin
            chk("ovf_ready_drop", int'(rdy_w[0]), 0);
            chk("ovf_count_full", int'(cnt_w[0]), 4);
            chk("ovf_not_yet", int'(ovf_w[0]), 0);
         end
         if (j == 5) begin
            chk("ovf_set", int'(ovf_w[0]), 1);
            chk("ovf_count_held", int'(cnt_w[0]), 4);
         end
      end
      stim_valid = 1'b0;
      wait_idle(700, bad);
      chk("ovf_five_frames_cycles", busy_n + bad, 5 * 99);

      // Reset during data bit 3 of a 0x00 frame with words still queued.
      stim_valid = 1'b1;
      stim_data  = 9'h000;
      repeat (3) cyc();
      stim_valid = 1'b0;
      repeat (37) cyc();
      chk("mid_bit3_low", int'(tx_w[0]), 0);
      chk("mid_queued", int'(cnt_w[0]), 2);
      @(posedge tb_clk_baudrate);
      #2 rst = 1'b1;
      #1;
      chk("rst_async_tx", int'(tx_w[0]), 1);
      chk("rst_async_busy", int'(busy_w[0]), 0);
      chk("rst_async_count", int'(cnt_w[0]), 0);
      chk("rst_async_overflow", int'(ovf_w[0]), 0);
      cyc();
      rst = 1'b0;
      bad = 0;
      repeat (120) begin
         cyc();
         if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) bad++;
      end
      chk("post_rst_idle_bad_cycles", bad, 0);

      // 5-bit, 2-tick configuration sends 0x15.
      send(9'h015);
      for (int k = 0; k < 18; k++) begin
         cyc();
         chk("d5_tx", int'(tx_w[3]), (k < 16) ? int'(d_frame[k / 2]) : 1);
         chk("d5_busy", int'(busy_w[3]), int'(k < 16));
      end
      wait_idle(300, bad);

      // Randomized traffic with one reset in the middle.
      for (int n = 0; n < 3000; n++) begin
         stim_valid = ($urandom_range(0, 99) < 25);
         stim_data  = 9'($urandom);
         if (n == 1500) rst = 1'b1;
         if (n == 1502) rst = 1'b0;
         cyc();
      end
      stim_valid = 1'b0;
      rst = 1'b0;
      wait_idle(2000, bad);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/uart_tx_framer.md
# uart_tx_framer

Buffered, parametrised UART transmitter: accepts words on a valid/ready interface into an internal FIFO and serialises them LSB-first on a single line. Data width, parity, stop-bit count, baud divisor and buffer depth are configurable. Sits beside `control_module` as the outbound companion to its UART receiver, and doubles as the synthesizable stimulus source for the 'L'/'R'/'r'/'b' command streams in benches and loopback builds.

## Interface
- `CLK_TICKS_PER_BIT`, 9: `clk_in` cycles per bit; must be ≥2.
- `CLK_TICKS_WIDTH`, 4: width of the bit-tick counter; must hold `CLK_TICKS_PER_BIT-1`.
- `DATA_BITS`, 8: payload bits per frame, 5..9.
- `PARITY`, 0: 0 none, 1 odd, 2 even.
- `STOP_BITS`, 2: 1 or 2.
- `FIFO_DEPTH`, 4: buffer entries; power of two, ≥2.
- `clk_in` in 1: single clock.
- `reset` in 1: asynchronous, active-high.
- `data_in` in `DATA_BITS`: word to send.
- `data_valid` in 1: `data_in` is offered this cycle.
- `data_ready` out 1: FIFO not full; a write is accepted on an edge where `data_valid && data_ready`.
- `tx_out` out 1: serial line, idle high.
- `tx_busy` out 1: high whenever the FSM is not in IDLE.
- `fifo_count` out `$clog2(FIFO_DEPTH)+1`: current occupancy.
- `overflow` out 1: sticky; set when `data_valid` is high while `data_ready` is low. Cleared only by reset.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: `tx_out`=1. If the FIFO is non-empty, pop the head into the shift register, compute parity, and go to START.
- START: `tx_out`=0 for one bit time, then go to DATA.
- DATA: drive shift[0] and shift right each bit time, for `DATA_BITS` bits. Then go to PARITY if `PARITY`≠0, else STOP.
- PARITY: drive the parity bit for one bit time. Even parity = XOR of the data bits; odd parity = its inverse.
- STOP: `tx_out`=1 for `STOP_BITS` bit times.
  - At the end of STOP, if the FIFO is non-empty, pop and go directly to START (no idle gap).
  - Otherwise go to IDLE.
- Bit time: the tick counter counts 0..`CLK_TICKS_PER_BIT-1` and resets on every state/bit advance.
- FIFO write and pop in the same cycle: count unchanged, both take effect.
- A rejected write (FIFO full) leaves FIFO contents unchanged and sets `overflow`.
- `data_in` is ignored when `data_valid` is low.

## Timing
- Reset values:
  - `tx_out`=1, `tx_busy`=0, `data_ready`=1, `fifo_count`=0, `overflow`=0.
  - FSM in IDLE, FIFO pointers 0.
- Reset mid-frame: the line returns high immediately (asynchronous) and the frame and buffered words are discarded.
- Latency: a word written into an empty FIFO on edge E with the FSM in IDLE is popped on edge E+1; `tx_out` falls after edge E+1.
- Frame length: (1 + `DATA_BITS` + (`PARITY`≠0) + `STOP_BITS`) × `CLK_TICKS_PER_BIT` cycles.
- `data_ready` is combinational from occupancy: `fifo_count` < `FIFO_DEPTH`. It does not anticipate a same-cycle pop.
- `fifo_count`, `tx_out`, `tx_busy` and `overflow` are registered.

## Structure
- Shared package `uart_pkg`:
  - parity encoding constants `PARITY_NONE/ODD/EVEN`;
  - FSM state typedef `uart_tx_state_t`;
  - these are reused by the matching parametrised receiver.
- One sub-module: `sync_fifo` (parameters WIDTH, DEPTH), providing push/pop/full/empty/count, with wrap-around pointers one bit wider than the address.
- Framer FSM, tick counter and shift register live in `uart_tx_framer`.

## Test plan
- Defaults, 8N2 (`PARITY`=0): write 0x4C ('L').
  - `tx_out` low 9 cycles, then bits 0,0,1,1,0,0,1,0 at 9 cycles each, then high 18 cycles.
  - Total 99 cycles; `tx_busy` falls after the last stop bit.
- `PARITY`=2, `STOP_BITS`=1: send 0x4C (three ones) → parity bit 1; with `PARITY`=1 → parity bit 0; frame length 99 cycles.
- Back-to-back: write 0x52, 0x72 on consecutive edges → the second start bit begins on the cycle after the first frame's last stop bit; `fifo_count` peaks at 1.
- Overflow: `FIFO_DEPTH`=4; write 6 words on consecutive edges while idle.
  - The first is popped at E+1; `data_ready` drops after the 5th accepted write.
  - The 6th is rejected, `overflow`=1, and 5 frames emerge in order.
- Reset mid-DATA: assert `reset` during bit 3 → `tx_out`=1, `fifo_count`=0, `tx_busy`=0 immediately.
  - After release, the line stays idle with no residual frame.
- `DATA_BITS`=5, `CLK_TICKS_PER_BIT`=2: send 0x15 → 0,1,0,1,0,1,1,1 with each bit 2 cycles wide.
